clk_freq_monitor: RTL and testbench

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

---
 rtl/clk_freq_monitor.sv | 132 +++++++++++++
 tb/tb_clk_freq_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Measures rising edges of mon_in per fixed sys_clk window and qualifies the rate.
// Define FREQ_MON_HYST_EN to require HYST_N consecutive windows before freq_ok changes.
module clk_freq_monitor #(
   parameter int unsigned WINDOW_CYCLES = 27000,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned MIN_COUNT     = 1000,
   parameter int unsigned MAX_COUNT     = 1100,
   parameter int unsigned HYST_N        = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             mon_in,
   input  logic             pll_lock,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             freq_ok,
   output logic             overflow
);

   localparam int unsigned      WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {WAIT_LOCK, MEASURE, EVAL} state_t;

   state_t           state;
   logic             mon_s1, mon_s2, mon_s3;
   logic             lock_s1, lock_s2;
   logic             edge_det;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             good;

`ifdef FREQ_MON_HYST_EN
   localparam int unsigned       HYST_W    = $clog2(HYST_N + 1);
   localparam logic [HYST_W-1:0] HYST_LAST = HYST_W'(HYST_N - 1);
   logic [HYST_W-1:0] good_run;
   logic [HYST_W-1:0] bad_run;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mon_s1  <= 1'b0;
         mon_s2  <= 1'b0;
         mon_s3  <= 1'b0;
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         mon_s1  <= mon_in;
         mon_s2  <= mon_s1;
         mon_s3  <= mon_s2;
         lock_s1 <= pll_lock;
         lock_s2 <= lock_s1;
      end
   end

   assign edge_det = mon_s2 & ~mon_s3;
   assign sat      = &edge_cnt;
   assign good     = !sat && (32'(edge_cnt) >= MIN_COUNT) && (32'(edge_cnt) <= MAX_COUNT);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= WAIT_LOCK;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         freq_ok     <= 1'b0;
         overflow    <= 1'b0;
`ifdef FREQ_MON_HYST_EN
         good_run    <= '0;
         bad_run     <= '0;
`endif
      end else begin
         count_valid <= 1'b0;
         if (!lock_s2) begin
            // Losing lock aborts the window silently; count_out keeps the last result.
            state    <= WAIT_LOCK;
            win_cnt  <= '0;
            edge_cnt <= '0;
            freq_ok  <= 1'b0;
`ifdef FREQ_MON_HYST_EN
            good_run <= '0;
            bad_run  <= '0;
`endif
         end else begin
            case (state)
               WAIT_LOCK: begin
                  win_cnt  <= '0;
                  edge_cnt <= '0;
                  state    <= MEASURE;
               end
               MEASURE: begin
                  win_cnt <= win_cnt + WIN_W'(1);
                  if (edge_det && !sat)
                     edge_cnt <= edge_cnt + CNT_W'(1);
                  if (win_cnt == WIN_LAST)
                     state <= EVAL;
               end
               EVAL: begin
                  count_out   <= edge_cnt;
                  count_valid <= 1'b1;
                  overflow    <= sat;
                  win_cnt     <= '0;
                  // An edge seen during EVAL opens the next window's count.
                  edge_cnt    <= edge_det ? CNT_W'(1) : '0;
                  state       <= MEASURE;
`ifdef FREQ_MON_HYST_EN
                  if (good) begin
                     bad_run <= '0;
                     if (good_run == HYST_LAST)
                        freq_ok <= 1'b1;
                     else
                        good_run <= good_run + HYST_W'(1);
                  end else begin
                     good_run <= '0;
                     if (bad_run == HYST_LAST)
                        freq_ok <= 1'b0;
                     else
                        bad_run <= bad_run + HYST_W'(1);
                  end
`else
                  freq_ok <= good;
`endif
               end
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor; three instances share stimulus with different limits.
module tb_clk_freq_monitor;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        mon_in    = 1'b0;
   logic        pll_lock  = 1'b0;
   int unsigned mon_period = 4;

   logic [15:0] cnt_a;
   logic        cv_a, ok_a, ovf_a;
   logic [3:0]  cnt_b;
   logic        cv_b, ok_b, ovf_b;
   logic [15:0] cnt_c;
   logic        cv_c, ok_c, ovf_c;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   clk_freq_monitor #(.WINDOW_CYCLES(100), .CNT_W(16), .MIN_COUNT(20), .MAX_COUNT(30), .HYST_N(3)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_in(mon_in), .pll_lock(pll_lock),
      .count_out(cnt_a), .count_valid(cv_a), .freq_ok(ok_a), .overflow(ovf_a));

   clk_freq_monitor #(.WINDOW_CYCLES(100), .CNT_W(4), .MIN_COUNT(20), .MAX_COUNT(30), .HYST_N(3)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_in(mon_in), .pll_lock(pll_lock),
      .count_out(cnt_b), .count_valid(cv_b), .freq_ok(ok_b), .overflow(ovf_b));

   clk_freq_monitor #(.WINDOW_CYCLES(100), .CNT_W(16), .MIN_COUNT(25), .MAX_COUNT(25), .HYST_N(3)) dut_c (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_in(mon_in), .pll_lock(pll_lock),
      .count_out(cnt_c), .count_valid(cv_c), .freq_ok(ok_c), .overflow(ovf_c));

   initial forever #5 sys_clk = ~sys_clk;

   // One-cycle high pulse every mon_period cycles, changed on the falling edge.
   initial begin
      int unsigned ph;
      ph = 0;
      forever begin
         @(negedge sys_clk);
         ph = (ph + 1 >= mon_period) ? 0 : ph + 1;
         mon_in = (ph == 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge sys_clk);
         #1;
         if (cv_a) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic        got;
      logic        seen;
      logic [15:0] hold;

      repeat (3) @(negedge sys_clk);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cv_a",  cv_a,  0);
      chk("rst_ok_a",  ok_a,  0);
      chk("rst_ovf_a", ovf_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      chk("rst_ovf_b", ovf_b, 0);

      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

`ifdef FREQ_MON_HYST_EN
      begin
         int unsigned per [9] = '{4, 4, 6, 4, 4, 4, 6, 6, 6};
         logic        exp_ok [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
         mon_period = per[0];
         repeat (10) @(negedge sys_clk);
         pll_lock = 1'b1;
         for (int k = 0; k < 9; k++) begin
            wait_valid(got);
            chk("hyst_valid", got, 1);
            chk($sformatf("hyst_ok_w%0d", k + 1), ok_a, exp_ok[k]);
            if (k < 8) mon_period = per[k + 1];
         end
      end
`else
      pll_lock = 1'b1;
      repeat (103) @(posedge sys_clk);
      #1;
      chk("lat_early_cv", cv_a, 0);
      @(posedge sys_clk);
      #1;
      chk("lat_cv_a",  cv_a,  1);
      chk("w1_cnt_a",  cnt_a, 25);
      chk("w1_ok_a",   ok_a,  1);
      chk("w1_ovf_a",  ovf_a, 0);
      chk("w1_cnt_b",  cnt_b, 15);
      chk("w1_ovf_b",  ovf_b, 1);
      chk("w1_ok_b",   ok_b,  0);
      chk("w1_ok_c",   ok_c,  1);
      @(posedge sys_clk);
      #1;
      chk("cv_pulse",  cv_a,  0);

      mon_period = 6;
      wait_valid(got);
      wait_valid(got);
      chk("p6_valid",  got, 1);
      chk("p6_cnt_in", (cnt_a == 16) || (cnt_a == 17), 1);
      chk("p6_ok_a",   ok_a, 0);

      mon_period = 3;
      wait_valid(got);
      wait_valid(got);
      chk("p3_valid",  got, 1);
      chk("p3_cnt_in", (cnt_a == 33) || (cnt_a == 34), 1);
      chk("p3_ok_a",   ok_a, 0);
      chk("p3_cnt_b",  cnt_b, 15);
      chk("p3_ovf_b",  ovf_b, 1);
      chk("p3_ok_b",   ok_b, 0);

      mon_period = 4;
      wait_valid(got);
      wait_valid(got);
      chk("p4_valid",  got, 1);
      chk("p4_cnt_in", (cnt_a == 25) || (cnt_a == 26), 1);
      chk("p4_ok_a",   ok_a, 1);
      chk("p4_ovf_a",  ovf_a, 0);

      hold = cnt_a;
      repeat (30) @(posedge sys_clk);
      @(negedge sys_clk);
      pll_lock = 1'b0;
      mon_period = 5;
      seen = 1'b0;
      repeat (3) begin
         @(posedge sys_clk);
         #1;
         seen |= cv_a;
      end
      chk("drop_ok_a", ok_a, 0);
      repeat (150) begin
         @(posedge sys_clk);
         #1;
         seen |= cv_a;
      end
      chk("drop_no_cv",  seen,  0);
      chk("drop_cnt_hd", cnt_a, hold);

      @(negedge sys_clk);
      pll_lock = 1'b1;
      repeat (103) @(posedge sys_clk);
      #1;
      chk("relock_early_cv", cv_a, 0);
      @(posedge sys_clk);
      #1;
      chk("relock_cv",  cv_a,  1);
      chk("relock_cnt", cnt_a, 20);
      chk("relock_ok",  ok_a,  1);

      repeat (50) @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("arst_cnt_a", cnt_a, 0);
      chk("arst_ok_a",  ok_a,  0);
      chk("arst_cv_a",  cv_a,  0);
      chk("arst_cnt_b", cnt_b, 0);
      chk("arst_ovf_b", ovf_b, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
